seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter: the drive side for the team's serial sequence detectors.
- Latches a pattern word and a length on `start`, then emits it MSB-first on `x`, one bit per clock.
- Can repeat the pattern N times, with a programmable idle gap between repeats.
- Used as on-chip stimulus and loopback source for detector blocks, including back-to-back repeats that exercise overlap detection.

Parameters:
- MAX_LEN, 16: maximum pattern length in bits.
- LEN_W, $clog2(MAX_LEN+1): width of the `len` input.
- REP_W, 8: width of the repeat count.
- GAP_W, 4: width of the gap-length input.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a transmission; sampled only in IDLE.
- pattern  in  MAX_LEN  bits to send; bit [len-1] goes out first.
- len  in  LEN_W  number of pattern bits, 1..MAX_LEN.
- repeat_cnt  in  REP_W  number of transmissions; 0 is treated as 1.
- gap  in  GAP_W  idle cycles between repeats; 0 means back-to-back.
- x  out  1  serial data; 0 whenever x_valid=0.
- x_valid  out  1  x carries a pattern bit this cycle.
- busy  out  1  transmission in progress; start is ignored.
- done  out  1  one-cycle pulse after the final bit.

Behaviour:
- All outputs are registered. Reset values: x=0, x_valid=0, busy=0, done=0, state=IDLE, all counters 0.
- State machine states: IDLE, SHIFT, GAP.
- Reset wins over every other event in the same cycle.
- Reset mid-operation: outputs return to reset values at the next edge, with no done pulse.
- IDLE:
  - start=1 with len in 1..MAX_LEN: latch pattern, len, max(repeat_cnt,1) and gap. Go to SHIFT.
  - The first bit pattern[len-1] appears on x with x_valid=1 in the cycle after the start edge, so latency is 1 cycle.
  - busy=1 from that same cycle.
- IDLE, illegal len: start with len=0 or len>MAX_LEN is ignored. State stays IDLE, no done, busy stays 0.
- SHIFT:
  - Emits bits len-1 down to 0 on consecutive cycles.
  - The bit index decrements each cycle; x_valid=1 throughout.
- After bit 0 with repeats remaining > 1:
  - Decrement the repeat count.
  - If gap>0, enter GAP for exactly gap cycles (x=0, x_valid=0, busy=1), then restart at bit len-1.
  - If gap=0, bit len-1 follows bit 0 on the very next cycle, with no bubble.
- After bit 0 of the final repeat:
  - Next cycle: state=IDLE, x_valid=0, x=0, busy=0, done=1 for exactly that cycle.
- start in the done cycle is accepted, because the state is IDLE. This gives a minimum gap of 1 idle cycle between separate transmissions.
- start while busy=1 is ignored. Input changes while busy have no effect, because all inputs are latched at start.
- Counter widths:
  - Bit index is LEN_W bits; it never wraps below 0 because the transition is taken at index 0.
  - Repeat counter is REP_W bits; the maximum of 2^REP_W-1 repeats is supported without overflow.
- Total cycles from start edge to done: R·len + (R-1)·gap + 1, where R = max(repeat_cnt,1).

Decomposition:
- Package seq_pkg:
  - state enum (IDLE, SHIFT, GAP);
  - default constants for MAX_LEN, REP_W and GAP_W.
- Single module; no sub-module is needed.
- The shift index, repeat counter and gap counter are plain registers inside the block.

Test Plan:
1. Basic send: pattern=7'b1011011, len=7, repeat_cnt=1, gap=0.
   - Cycles 1–7 after start: x=1,0,1,1,0,1,1 with x_valid=1.
   - Cycle 8: done=1, busy=0.
2. Back-to-back repeat: same pattern, repeat_cnt=2, gap=0.
   - 14 consecutive valid bits, 1011011 1011011, with no bubble.
   - done at cycle 15.
   - Loopback into seq_overlap: y matches a golden detector model cycle-for-cycle.
3. Gap between repeats: pattern=4'b1011, len=4, repeat_cnt=3, gap=2.
   - Sequence: 1011, 2 cycles of x_valid=0, 1011, 2 idle cycles, 1011.
   - done at cycle 17.
4. Ignored starts:
   - len=0 with start: busy stays 0, no done.
   - start pulsed again at cycle 3 of an active 7-bit send: output identical to scenario 1.
5. Reset mid-shift: assert rst for 1 cycle at cycle 4 of scenario 1.
   - Next edge: x=0, x_valid=0, busy=0, and done never pulses.
   - A fresh start afterwards transmits cleanly.
6. Corner cases:
   - len=MAX_LEN=16, pattern=16'h8001, repeat_cnt=0: exactly one transmission, 1 then fourteen 0s then 1, done at cycle 17.
   - start held high through done: a second transmission begins at the cycle after done.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e      : transmitter FSM states
//   DEF_MAX_LEN  : default maximum pattern length in bits
//   DEF_REP_W    : default repeat-count width
//   DEF_GAP_W    : default gap-length width
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_LEN = 16;
    localparam int unsigned DEF_REP_W   = 8;
    localparam int unsigned DEF_GAP_W   = 4;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. Latches a pattern/length on start and shifts it out
// MSB-first (bit len-1 first), optionally repeating it with an idle gap between repeats.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : request a transmission (sampled in IDLE only)
//   pattern    : bits to send
//   len        : pattern length, 1..MAX_LEN (others ignored)
//   repeat_cnt : number of transmissions, 0 treated as 1
//   gap        : idle cycles between repeats
//   x          : serial data, 0 when not valid
//   x_valid    : x carries a pattern bit
//   busy       : transmission in progress
//   done       : one-cycle pulse after the final bit
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned REP_W   = DEF_REP_W,
    parameter int unsigned GAP_W   = DEF_GAP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   repeat_cnt,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
    localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);
    localparam logic [REP_W-1:0] RepOne = REP_W'(1);
    localparam logic [GAP_W-1:0] GapOne = GAP_W'(1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               len_ok;
    logic [MAX_LEN-1:0] start_sh, next_sh, wrap_sh;

    assign len_ok = (len != '0) && (len <= LenMax);

    // Bit selects done by shifting so the index width need not match the pattern width.
    assign start_sh = pattern >> (len - LenOne);
    assign next_sh  = pat_q >> (idx_q - LenOne);
    assign wrap_sh  = pat_q >> (len_q - LenOne);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d   = SHIFT;
                    pat_d     = pattern;
                    len_d     = len;
                    idx_d     = len - LenOne;
                    rep_d     = (repeat_cnt == '0) ? RepOne : repeat_cnt;
                    gap_d     = gap;
                    x_d       = start_sh[0];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (idx_q != '0) begin
                    idx_d     = idx_q - LenOne;
                    x_d       = next_sh[0];
                    x_valid_d = 1'b1;
                end else if (rep_q > RepOne) begin
                    rep_d = rep_q - RepOne;
                    if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        // Back-to-back: MSB follows bit 0 with no bubble.
                        idx_d     = len_q - LenOne;
                        x_d       = wrap_sh[0];
                        x_valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    rep_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                // Last gap cycle launches the MSB so the gap is exactly gap_q cycles long.
                if (gap_cnt_q == GapOne) begin
                    state_d   = SHIFT;
                    gap_cnt_d = '0;
                    idx_d     = len_q - LenOne;
                    x_d       = wrap_sh[0];
                    x_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
